// File: rtl/rtc_bus_sequencer_if.sv
// Request and bus signals for rtc_bus_sequencer.
//   slave  : the sequencer side. It takes the two requester channels and ad_in,
//            and drives the latches, selector controls, strobes, read data and
//            completion/busy status.
//   master : the requester/environment side, with the directions reversed.
interface rtc_bus_sequencer_if;
  logic       req0;
  logic       wr0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       req1;
  logic       wr1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic [7:0] ad_in;
  logic [7:0] addr_lat;
  logic [7:0] data_lat;
  logic       mux_ch0_sel;
  logic       mux_ch1_sel;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] rd_data;
  logic       done0;
  logic       done1;
  logic       busy;

  modport slave (
    input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ad_in,
    output addr_lat, data_lat, mux_ch0_sel, mux_ch1_sel, ad_oe, cs_n, ad_n,
           wr_n, rd_n, rd_data, done0, done1, busy
  );

  modport master (
    output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ad_in,
    input  addr_lat, data_lat, mux_ch0_sel, mux_ch1_sel, ad_oe, cs_n, ad_n,
           wr_n, rd_n, rd_data, done0, done1, busy
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the shared 8-bit multiplexed address/data bus to the RTC.
// It round-robin arbitrates between requester 0 (write path) and requester 1
// (read/refresh path). Each access runs as an address phase (set/strobe/hold)
// followed by a data phase (set/strobe/hold). Each of those states lasts
// PHASE_CYC cycles. A RECOVER gap of RECOV_CYC cycles follows every access.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : rtc_bus_sequencer_if.slave, carrying the requests, ad_in, the
//           latches, the selector controls, the strobes, rd_data and done/busy
module rtc_bus_sequencer #(
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned RECOV_CYC = 2
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_sequencer_if.slave bus
);

  localparam int unsigned MAXC = (PHASE_CYC > RECOV_CYC) ? PHASE_CYC : RECOV_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PH = cnt_t'(PHASE_CYC);
  localparam cnt_t RC = cnt_t'(RECOV_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SET, S_A_STB, S_A_HOLD, S_D_SET, S_D_STB, S_D_HOLD, S_RECOVER
  } state_t;

  state_t     r_state, w_state_nxt;
  cnt_t       r_cnt, w_cnt_nxt;
  logic       r_gnt, r_last, r_wr;
  logic [7:0] r_addr, r_wdata, r_rd;

  logic w_any, w_pick1, w_last_cyc;
  logic w_cs_n, w_ad_n, w_wr_n, w_rd_n, w_oe, w_sel0, w_sel1, w_done0, w_done1;

  assign w_any      = bus.req0 | bus.req1;
  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 held the previous grant.
  assign w_pick1    = bus.req1 & (~bus.req0 | ~r_last);
  assign w_last_cyc = (r_cnt == cnt_t'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state != S_IDLE) w_cnt_nxt = r_cnt - cnt_t'(1);
    case (r_state)
      S_IDLE:    if (w_any)      begin w_state_nxt = S_A_SET;   w_cnt_nxt = PH; end
      S_A_SET:   if (w_last_cyc) begin w_state_nxt = S_A_STB;   w_cnt_nxt = PH; end
      S_A_STB:   if (w_last_cyc) begin w_state_nxt = S_A_HOLD;  w_cnt_nxt = PH; end
      S_A_HOLD:  if (w_last_cyc) begin w_state_nxt = S_D_SET;   w_cnt_nxt = PH; end
      S_D_SET:   if (w_last_cyc) begin w_state_nxt = S_D_STB;   w_cnt_nxt = PH; end
      S_D_STB:   if (w_last_cyc) begin w_state_nxt = S_D_HOLD;  w_cnt_nxt = PH; end
      S_D_HOLD:  if (w_last_cyc) begin w_state_nxt = S_RECOVER; w_cnt_nxt = RC; end
      S_RECOVER: if (w_last_cyc) begin w_state_nxt = S_IDLE; end
      default:   w_state_nxt = S_IDLE;
    endcase

    w_cs_n  = 1'b1;
    w_ad_n  = 1'b1;
    w_wr_n  = 1'b1;
    w_rd_n  = 1'b1;
    w_oe    = 1'b0;
    w_sel0  = 1'b0;
    w_sel1  = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    case (r_state)
      S_A_SET, S_A_STB, S_A_HOLD: begin
        w_cs_n = 1'b0;
        w_ad_n = 1'b0;
        w_oe   = 1'b1;
        w_sel0 = 1'b1;
        w_wr_n = (r_state != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HOLD: begin
        w_cs_n = 1'b0;
        w_oe   = r_wr;
        if (r_state == S_D_STB) begin
          w_wr_n = ~r_wr;
          w_rd_n = r_wr;
        end
      end
      S_RECOVER: begin
        // The counter is reloaded on entry, so RC marks the first RECOVER cycle.
        if (r_cnt == RC) begin
          w_done0 = ~r_gnt;
          w_done1 = r_gnt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_gnt   <= w_pick1;
        r_last  <= w_pick1;
        r_wr    <= w_pick1 ? bus.wr1    : bus.wr0;
        r_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
        r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == S_D_STB && w_last_cyc && !r_wr) r_rd <= bus.ad_in;
    end
  end

  assign bus.addr_lat    = r_addr;
  assign bus.data_lat    = r_wdata;
  assign bus.rd_data     = r_rd;
  assign bus.mux_ch0_sel = w_sel0;
  assign bus.mux_ch1_sel = w_sel1;
  assign bus.ad_oe       = w_oe;
  assign bus.cs_n        = w_cs_n;
  assign bus.ad_n        = w_ad_n;
  assign bus.wr_n        = w_wr_n;
  assign bus.rd_n        = w_rd_n;
  assign bus.done0       = w_done0;
  assign bus.done1       = w_done1;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;
  localparam int P = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if ifa ();
  rtc_bus_sequencer_if ifb ();

  rtc_bus_sequencer #(.PHASE_CYC(P), .RECOV_CYC(R)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  rtc_bus_sequencer #(.PHASE_CYC(1), .RECOV_CYC(1)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  int checks = 0;
  int passed = 0;
  int inv_viol = 0;
  int cyc = 0;
  int done_q[$];

  // Reference model state: which requester won the previous grant, and the
  // read data the bus should currently be presenting.
  bit         m_last = 1'b1;
  logic [7:0] m_rd = 8'h00;

  always @(posedge clk) cyc++;

  // Control-output vector:
  // {cs_n, ad_n, wr_n, rd_n, ad_oe, sel0, sel1, done0, done1, busy}
  function automatic logic [9:0] ctl_a();
    return {ifa.cs_n, ifa.ad_n, ifa.wr_n, ifa.rd_n, ifa.ad_oe, ifa.mux_ch0_sel,
            ifa.mux_ch1_sel, ifa.done0, ifa.done1, ifa.busy};
  endfunction
  function automatic logic [9:0] ctl_b();
    return {ifb.cs_n, ifb.ad_n, ifb.wr_n, ifb.rd_n, ifb.ad_oe, ifb.mux_ch0_sel,
            ifb.mux_ch1_sel, ifb.done0, ifb.done1, ifb.busy};
  endfunction

  always @(negedge clk) begin
    if (ifa.done0 || ifa.done1) done_q.push_back(cyc);
    if ((!ifa.wr_n && !ifa.rd_n) || (ifa.cs_n && (!ifa.wr_n || !ifa.rd_n)) ||
        (!ifa.rd_n && ifa.ad_oe) || (ifa.done0 && ifa.done1)) inv_viol++;
    if ((!ifb.wr_n && !ifb.rd_n) || (ifb.cs_n && (!ifb.wr_n || !ifb.rd_n)) ||
        (!ifb.rd_n && ifb.ad_oe) || (ifb.done0 && ifb.done1)) inv_viol++;
  end

  // Round-robin rule: a lone request wins; on contention the one not granted last wins.
  function automatic bit arb(bit r0, bit r1);
    return (r0 && r1) ? !m_last : r1;
  endfunction

  // Called at a negedge when the DUT is idle and a request is pending, so the
  // next posedge is the grant edge. Checks every cycle until the following IDLE
  // cycle and returns at that negedge.
  task automatic expect_txn(input bit id, input bit wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] adin, input bit hold);
    logic [9:0] exp;
    logic [7:0] cap;
    int ph;
    cap = 8'h00;
    @(posedge clk);
    m_last = id;
    for (int k = 0; k < 6*P + R + 1; k++) begin
      @(negedge clk);
      ph = k / P;
      if (k < 6*P && ph < 3)
        exp = {1'b0, 1'b0, (ph != 1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      else if (k < 6*P)
        exp = {1'b0, 1'b1, !(ph == 4 && wr), !(ph == 4 && !wr), wr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      else if (k < 6*P + R)
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (k == 6*P) && !id, (k == 6*P) && id, 1'b1};
      else
        exp = 10'b11110_00000;
      if (!wr && k == 5*P) m_rd = cap;
      checks++;
      if (ctl_a() !== exp) $display("FAIL txn_ctl k=%0d id=%0d got=%b exp=%b", k, id, ctl_a(), exp);
      else passed++;
      checks++;
      if (ifa.addr_lat !== addr || ifa.data_lat !== wdata)
        $display("FAIL txn_lat k=%0d got=%h/%h exp=%h/%h", k, ifa.addr_lat, ifa.data_lat, addr, wdata);
      else passed++;
      checks++;
      if (ifa.rd_data !== m_rd) $display("FAIL txn_rd k=%0d got=%h exp=%h", k, ifa.rd_data, m_rd);
      else passed++;
      if (!hold && k == 0) begin ifa.req0 = 1'b0; ifa.req1 = 1'b0; end
      ifa.ad_in = (k >= 4*P && k < 5*P) ? adin : 8'($urandom);
      if (k == 5*P - 1) cap = ifa.ad_in;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    {ifa.req0, ifa.wr0, ifa.req1, ifa.wr1} = '0;
    {ifa.addr0, ifa.wdata0, ifa.addr1, ifa.wdata1, ifa.ad_in} = '0;
    {ifb.req0, ifb.wr0, ifb.req1, ifb.wr1} = '0;
    {ifb.addr0, ifb.wdata0, ifb.addr1, ifb.wdata1, ifb.ad_in} = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ctl_a() !== 10'b11110_00000) $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a(), 10'b11110_00000);
    else passed++;
    checks++;
    if (ctl_b() !== 10'b11110_00000) $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b(), 10'b11110_00000);
    else passed++;
    checks++;
    if ({ifa.addr_lat, ifa.data_lat, ifa.rd_data} !== 24'h0)
      $display("FAIL reset_regs got=%h exp=000000", {ifa.addr_lat, ifa.data_lat, ifa.rd_data});
    else passed++;
    rst_a = 1'b0; rst_b = 1'b0;
    m_last = 1'b1; m_rd = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl_a() !== 10'b11110_00000) $display("FAIL idle_after_reset got=%b exp=%b", ctl_a(), 10'b11110_00000);
    else passed++;
  endtask

  task automatic test_contention();
    bit id;
    done_q.delete();
    ifa.req0 = 1'b1; ifa.wr0 = 1'b1; ifa.addr0 = 8'h10; ifa.wdata0 = 8'hA5;
    ifa.req1 = 1'b1; ifa.wr1 = 1'b0; ifa.addr1 = 8'h11; ifa.wdata1 = 8'h5A;
    for (int n = 0; n < 4; n++) begin
      id = arb(1'b1, 1'b1);
      checks++;
      if (id !== n[0]) $display("FAIL contention_order n=%0d got=%0d exp=%0d", n, id, n[0]);
      else passed++;
      if (id) expect_txn(1'b1, 1'b0, 8'h11, 8'h5A, 8'($urandom), 1'b1);
      else    expect_txn(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b1);
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    checks++;
    if (done_q.size() != 4) $display("FAIL contention_done_count got=%0d exp=4", done_q.size());
    else passed++;
    for (int n = 1; n < done_q.size(); n++) begin
      checks++;
      if (done_q[n] - done_q[n-1] != 6*P + R + 1)
        $display("FAIL contention_spacing got=%0d exp=%0d", done_q[n] - done_q[n-1], 6*P + R + 1);
      else passed++;
    end
  endtask

  task automatic test_read();
    ifa.req1 = 1'b1; ifa.wr1 = 1'b0; ifa.addr1 = 8'h22; ifa.wdata1 = 8'h99;
    expect_txn(arb(1'b0, 1'b1), 1'b0, 8'h22, 8'h99, 8'h37, 1'b0);
    checks++;
    if (ifa.rd_data !== 8'h37) $display("FAIL read_data got=%h exp=37", ifa.rd_data);
    else passed++;
  endtask

  task automatic test_write();
    ifa.req0 = 1'b1; ifa.wr0 = 1'b1; ifa.addr0 = 8'h21; ifa.wdata0 = 8'h45;
    expect_txn(arb(1'b1, 1'b0), 1'b1, 8'h21, 8'h45, 8'hEE, 1'b0);
    checks++;
    if (ifa.rd_data !== 8'h37) $display("FAIL write_keeps_rd got=%h exp=37", ifa.rd_data);
    else passed++;
  endtask

  task automatic test_drop_and_late_req();
    ifa.req0 = 1'b1; ifa.wr0 = 1'b1; ifa.addr0 = 8'h33; ifa.wdata0 = 8'hC3;
    fork
      expect_txn(arb(1'b1, 1'b0), 1'b1, 8'h33, 8'hC3, 8'h00, 1'b1);
      begin
        @(posedge clk);
        repeat (2*P + 1) @(negedge clk);
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b1; ifa.wr1 = 1'b0; ifa.addr1 = 8'h44; ifa.wdata1 = 8'h00;
      end
    join
    expect_txn(arb(1'b0, 1'b1), 1'b0, 8'h44, 8'h00, 8'h6B, 1'b0);
  endtask

  task automatic test_random();
    bit r0, r1, id, w0, w1;
    logic [7:0] a0, a1, d0, d1, ai;
    for (int n = 0; n < 8; n++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = 8'($urandom); a1 = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      ai = 8'($urandom);
      ifa.req0 = r0; ifa.wr0 = w0; ifa.addr0 = a0; ifa.wdata0 = d0;
      ifa.req1 = r1; ifa.wr1 = w1; ifa.addr1 = a1; ifa.wdata1 = d1;
      id = arb(r0, r1);
      fork
        if (id) expect_txn(1'b1, w1, a1, d1, ai, 1'b0);
        else    expect_txn(1'b0, w0, a0, d0, ai, 1'b0);
        begin
          // Busy-time request noise must neither start a transaction nor
          // disturb the latched address/data.
          @(posedge clk);
          @(negedge clk);
          for (int k = 1; k < 6*P; k++) begin
            @(negedge clk);
            ifa.req0 = 1'($urandom); ifa.req1 = 1'($urandom);
            ifa.wr0 = 1'($urandom); ifa.wr1 = 1'($urandom);
            ifa.addr0 = 8'($urandom); ifa.addr1 = 8'($urandom);
            ifa.wdata0 = 8'($urandom); ifa.wdata1 = 8'($urandom);
          end
          @(negedge clk);
          ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        end
      join
    end
  endtask

  task automatic test_reset_mid_write();
    done_q.delete();
    ifa.req0 = 1'b1; ifa.wr0 = 1'b1; ifa.addr0 = 8'h5C; ifa.wdata0 = 8'h71;
    @(posedge clk);
    @(negedge clk);
    ifa.req0 = 1'b0;
    repeat (4*P + 1) @(negedge clk);
    checks++;
    if (ifa.wr_n !== 1'b0) $display("FAIL midreset_in_dstb wr_n got=%b exp=0", ifa.wr_n);
    else passed++;
    #1 rst_a = 1'b1;
    #1;
    checks++;
    if (ctl_a() !== 10'b11110_00000) $display("FAIL midreset_ctl got=%b exp=%b", ctl_a(), 10'b11110_00000);
    else passed++;
    checks++;
    if ({ifa.addr_lat, ifa.data_lat, ifa.rd_data} !== 24'h0)
      $display("FAIL midreset_regs got=%h exp=000000", {ifa.addr_lat, ifa.data_lat, ifa.rd_data});
    else passed++;
    m_last = 1'b1; m_rd = 8'h00;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_q.size() != 0) $display("FAIL midreset_no_done got=%0d pulses exp=0", done_q.size());
    else passed++;
    ifa.req0 = 1'b1; ifa.wr0 = 1'b1; ifa.addr0 = 8'h5D; ifa.wdata0 = 8'h72;
    expect_txn(arb(1'b1, 1'b0), 1'b1, 8'h5D, 8'h72, 8'h00, 1'b0);
  endtask

  task automatic test_fast_build();
    logic [9:0] tbl [8];
    logic [7:0] a, d;
    tbl[0] = 10'b00111_10001; tbl[1] = 10'b00011_10001;
    tbl[2] = 10'b00111_10001; tbl[3] = 10'b01111_00001;
    tbl[4] = 10'b01011_00001; tbl[5] = 10'b01111_00001;
    tbl[6] = 10'b11110_00101; tbl[7] = 10'b11110_00000;
    a = 8'($urandom); d = 8'($urandom);
    ifb.req0 = 1'b1; ifb.wr0 = 1'b1; ifb.addr0 = a; ifb.wdata0 = d;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifb.req0 = 1'b0;
      checks++;
      if (ctl_b() !== tbl[k]) $display("FAIL fast_ctl k=%0d got=%b exp=%b", k, ctl_b(), tbl[k]);
      else passed++;
    end
    checks++;
    if (ifb.addr_lat !== a || ifb.data_lat !== d)
      $display("FAIL fast_lat got=%h/%h exp=%h/%h", ifb.addr_lat, ifb.data_lat, a, d);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_read();
    test_write();
    test_drop_and_late_req();
    test_random();
    test_reset_mid_write();
    test_fast_build();
    checks++;
    if (inv_viol != 0) $display("FAIL bus_invariants got=%0d violations exp=0", inv_viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Controller for the shared 8-bit multiplexed address/data bus to the RTC.
- Arbitrates between two requesters (req 0 = write path, req 1 = read/refresh path) using round-robin.
- Sequences each access as an address phase followed by a data phase, and generates the active-low bus strobes.
- Drives the select inputs of the downstream 8-bit two-channel selector: ch0 carries the address, ch1 carries the write data.

Parameters:
PHASE_CYC, 4, clock cycles per bus phase (>=1)
RECOV_CYC, 2, bus-idle cycles between transactions (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req0  in  1  requester 0 access request (level)
wr0  in  1  requester 0 direction: 1 = write, 0 = read
addr0  in  8  requester 0 register address
wdata0  in  8  requester 0 write data
req1  in  1  requester 1 access request (level)
wr1  in  1  requester 1 direction
addr1  in  8  requester 1 register address
wdata1  in  8  requester 1 write data
ad_in  in  8  bus read-back value
addr_lat  out  8  latched address, feeds the selector's ch0
data_lat  out  8  latched write data, feeds the selector's ch1
mux_ch0_sel  out  1  selector control A
mux_ch1_sel  out  1  selector control B
ad_oe  out  1  bus output enable
cs_n  out  1  chip select, active low
ad_n  out  1  0 = address phase, 1 = data phase
wr_n  out  1  write strobe, active low
rd_n  out  1  read strobe, active low
rd_data  out  8  captured read data
done0  out  1  one-cycle completion pulse for requester 0
done1  out  1  one-cycle completion pulse for requester 1
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State = IDLE.
  - cs_n, ad_n, wr_n, rd_n = 1.
  - ad_oe, mux_ch0_sel, mux_ch1_sel, done0, done1, busy = 0.
  - addr_lat, data_lat, rd_data = 0x00.
  - last_grant = 1, so req0 wins the first contention.
- Selector encoding:
  - Address phases: (mux_ch0_sel, mux_ch1_sel) = (1,0), selecting ch0/address.
  - All other states: (0,0), selecting ch1/data.
- Arbitration happens only in IDLE:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch addr, wdata, wr and grant id; update last_grant.
  - Requests are ignored outside IDLE. Deasserting req mid-transaction does not abort it.
- Timing counter: each timed state lasts exactly PHASE_CYC cycles (RECOVER lasts RECOV_CYC). The counter reloads on every state entry.
- States and outputs (outputs not listed keep their idle values):
  - IDLE: on grant, go to A_SET next cycle.
  - A_SET: cs_n=0, ad_n=0, ad_oe=1, sel=(1,0).
  - A_STB: as A_SET plus wr_n=0 (address latch strobe).
  - A_HOLD: as A_SET, wr_n=1.
  - D_SET: cs_n=0, ad_n=1, sel=(0,0). ad_oe=1 if write, 0 if read.
  - D_STB: as D_SET plus wr_n=0 (write) or rd_n=0 (read). On a read, ad_in is captured into rd_data at the last cycle of D_STB.
  - D_HOLD: strobes high, cs_n=0, ad_oe keeps its D_SET value.
  - RECOVER: cs_n=1, ad_oe=0. done for the granted requester is high in the first RECOVER cycle only. After RECOV_CYC cycles, go to IDLE.
- Latency and data retention:
  - Grant edge to done pulse = 6*PHASE_CYC cycles.
  - Grant edge to next possible grant = 6*PHASE_CYC + RECOV_CYC + 1 cycles.
  - rd_data holds its value until the next read capture; writes do not change it.
- Invariants:
  - wr_n and rd_n are never low together.
  - No strobe is low while cs_n=1.
  - ad_oe=0 whenever rd_n=0.
  - done0 and done1 are never high together.
- Back-to-back: a requester holding req high through done is re-eligible in the following IDLE, still subject to round-robin.

Test Plan:
- Write (PHASE_CYC=4, RECOV_CYC=2): req0=1, wr0=1, addr0=0x21, wdata0=0x45.
  - -> addr_lat=0x21 with sel=(1,0) and wr_n low for 4 cycles.
  - -> then data_lat=0x45 with ad_oe=1 and wr_n low for 4 cycles.
  - -> done0 pulses exactly 24 cycles after grant; rd_data unchanged.
- Read: req1=1, wr1=0, addr1=0x22, ad_in=0x37 during D_STB.
  - -> rd_n low 4 cycles with ad_oe=0.
  - -> rd_data=0x37 at done1; wr_n never low in the data phase.
- Contention: req0 and req1 held high continuously after reset.
  - -> grant order 0,1,0,1.
  - -> each done one-cycle; done0/done1 spaced 27 cycles apart.
- Reset while in D_STB of a write.
  - -> same cycle: wr_n=1, cs_n=1, ad_oe=0, busy=0.
  - -> no done pulse; next req0 starts a fresh A_SET.
- Requester drops req0 during A_HOLD, and req1 rises mid-transaction.
  - -> transaction 0 completes with done0.
  - -> req1 is granted only after RECOVER.
- PHASE_CYC=1, RECOV_CYC=1 build: single write.
  - -> each state exactly one cycle; done0 6 cycles after grant; invariants hold (assertion-checked).
